// File: rtl/adaptive_filter_seq.sv
// adaptive_filter_seq: LMS adaptive FIR filter with a single multiplier
// time-shared across filtering, error scaling and weight update.
// Optional leaky-LMS weight update: define ADAPTIVE_FILTER_LEAK_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a sample; weights_clr honoured here
// S_FILTER | TAPS cycles, acc += w[k]*x[k]
// S_ERROR  | 1 cycle, y/e/mu_e computed, dout/error registered
// S_UPDATE | TAPS cycles, w[k] adapted when the latched adapt_en is set
module adaptive_filter_seq #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 7,
    parameter int TAPS       = 2,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             din,
    input  logic [WIDTH-1:0]             desired,
    input  logic [WIDTH-1:0]             step_size,
    input  logic                         adapt_en,
    input  logic                         weights_clr,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             dout,
    output logic [WIDTH-1:0]             error,
    output logic [TAPS-1:0][WIDTH-1:0]   weights
);

    localparam int CW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = 2 * WIDTH + $clog2(TAPS);
    localparam int SAT_W = ACC_W + 1;

    localparam logic signed [SAT_W-1:0] SAT_MAX = {{(SAT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] SAT_MIN = {{(SAT_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILTER = 2'd1,
        S_ERROR  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SAT_W-1:0] v);
        if (v > SAT_MAX)      sat = {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < SAT_MIN) sat = {1'b1, {(WIDTH-1){1'b0}}};
        else                  sat = v[WIDTH-1:0];
    endfunction

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CW-1:0]                 r_cnt;
    logic [TAPS-1:0][WIDTH-1:0]    r_x;
    logic [TAPS-1:0][WIDTH-1:0]    r_w;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [WIDTH-1:0]       r_d;
    logic signed [WIDTH-1:0]       r_mu;
    logic                          r_adapt;
    logic signed [WIDTH-1:0]       r_mu_e;
    logic [WIDTH-1:0]              r_dout;
    logic [WIDTH-1:0]              r_error;
    logic                          r_out_valid;

    logic                          w_accept;
    logic [CW-1:0]                 w_k;
    logic signed [WIDTH-1:0]       w_xk;
    logic signed [WIDTH-1:0]       w_wk;
    logic signed [WIDTH-1:0]       w_mul_a;
    logic signed [WIDTH-1:0]       w_mul_b;
    logic signed [PW-1:0]          w_prod;
    logic signed [PW-1:0]          w_prod_sh;
    logic signed [ACC_W-1:0]       w_acc_sh;
    logic signed [WIDTH-1:0]       w_y;
    logic signed [SAT_W-1:0]       w_e_full;
    logic signed [WIDTH-1:0]       w_e;
    logic signed [WIDTH-1:0]       w_mue;
    logic signed [SAT_W-1:0]       w_upd_sum;
    logic signed [WIDTH-1:0]       w_w_new;

    assign in_ready  = (r_state == S_IDLE) && !weights_clr;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign error     = r_error;
    assign weights   = r_w;

    // Counter runs down; tap index counts up from 0 alongside it.
    assign w_k  = CW'(TAPS - 1) - r_cnt;
    assign w_xk = r_x[w_k];
    assign w_wk = r_w[w_k];

    assign w_acc_sh = r_acc >>> FRAC;
    assign w_y      = sat(SAT_W'(w_acc_sh));
    assign w_e_full = SAT_W'(r_d) - SAT_W'(w_y);
    assign w_e      = sat(w_e_full);

    assign w_prod    = PW'(w_mul_a) * PW'(w_mul_b);
    assign w_prod_sh = w_prod >>> FRAC;
    assign w_mue     = sat(SAT_W'(w_prod_sh));

`ifdef ADAPTIVE_FILTER_LEAK_EN
    logic signed [WIDTH-1:0] w_leak;
    assign w_leak    = w_wk >>> LEAK_SHIFT;
    assign w_upd_sum = SAT_W'(w_wk) - SAT_W'(w_leak) + SAT_W'(w_prod_sh);
`else
    assign w_upd_sum = SAT_W'(w_wk) + SAT_W'(w_prod_sh);
`endif
    assign w_w_new = sat(w_upd_sum);

    // Shared multiplier operand select: w*x in FILTER, mu*e in ERROR, mu_e*x in UPDATE.
    always_comb begin
        w_mul_a = r_mu_e;
        w_mul_b = w_xk;
        case (r_state)
            S_FILTER: w_mul_a = w_wk;
            S_ERROR: begin
                w_mul_a = r_mu;
                w_mul_b = w_e;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)      w_state_nxt = S_FILTER;
            S_FILTER: if (r_cnt == '0)   w_state_nxt = S_ERROR;
            S_ERROR:                     w_state_nxt = S_UPDATE;
            S_UPDATE: if (r_cnt == '0)   w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: delay line, accumulator, outputs and weight registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_x         <= '0;
            r_w         <= '0;
            r_acc       <= '0;
            r_d         <= '0;
            r_mu        <= '0;
            r_adapt     <= 1'b0;
            r_mu_e      <= '0;
            r_dout      <= '0;
            r_error     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (weights_clr) begin
                        r_w <= '0;
                    end else if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
                        r_x[0]  <= din;
                        r_d     <= desired;
                        r_mu    <= step_size;
                        r_adapt <= adapt_en;
                        r_acc   <= '0;
                        r_cnt   <= CW'(TAPS - 1);
                    end
                end
                S_FILTER: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_cnt <= r_cnt - CW'(1);
                end
                S_ERROR: begin
                    r_dout  <= w_y;
                    r_error <= w_e;
                    r_mu_e  <= w_mue;
                    r_cnt   <= CW'(TAPS - 1);
                end
                S_UPDATE: begin
                    if (r_adapt) r_w[w_k] <= w_w_new;
                    if (r_cnt == '0) r_out_valid <= 1'b1;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adaptive_filter_seq.md
Name: adaptive_filter_seq

Overview:
- Next-generation LMS adaptive FIR filter. Single shared multiplier, time-multiplexed over the taps.
- Sample-level valid/ready handshake; per-sample adapt/freeze control; weight clear; saturating fixed-point arithmetic throughout.
- Sits between the sample source and the output/error monitors in the filter datapath.
- Intended as the drop-in successor for larger TAPS counts, where a fully parallel MAC array is too costly.

Parameters:
WIDTH, 16, sample/weight/step width; signed two's complement
FRAC, 7, fractional bits (Q(WIDTH-FRAC).FRAC); 1.0 = 2^FRAC
TAPS, 2, filter length, >= 1
LEAK_SHIFT, 8, leakage shift (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous active-low reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
din  in  WIDTH  input sample x[n]
desired  in  WIDTH  desired sample d[n]
step_size  in  WIDTH  mu (Q format), sampled on accept
adapt_en  in  1  1 = update weights for this sample, sampled on accept
weights_clr  in  1  zero all weights (honoured in IDLE only)
out_valid  out  1  one-cycle pulse: dout/error/weights updated
dout  out  WIDTH  filter output y[n]
error  out  WIDTH  e[n] = d[n] - y[n]
weights  out  [TAPS-1:0][WIDTH-1:0]  current tap weights, w[0] applies to newest sample

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; delay line, weights, dout, error, accumulator = 0; out_valid=0. Reset mid-operation aborts the sample; no partial weight update survives.
- in_ready = (state==IDLE) && !weights_clr.
- Accept happens at a posedge with in_valid && in_ready:
  - shift delay line: x[k] <= x[k-1], x[0] <= din;
  - latch desired, step_size, adapt_en;
  - clear the accumulator; go to FILTER.
- FILTER, TAPS cycles, k = 0..TAPS-1: acc += w[k]*x[k].
  - acc width 2*WIDTH+clog2(TAPS); full precision, no saturation inside the accumulator.
- ERROR, 1 cycle:
  - y = sat(acc >>> FRAC);
  - e = sat(d - y), computed at WIDTH+1 bits;
  - mu_e = sat((mu*e) >>> FRAC);
  - dout <= y, error <= e.
- UPDATE, TAPS cycles, k = 0..TAPS-1: if the latched adapt_en is set, w[k] <= sat(w[k] + ((mu_e*x[k]) >>> FRAC)); otherwise w[k] is unchanged. The cycle count is the same either way.
- IDLE: entered after the last UPDATE cycle; out_valid = 1 for exactly this first IDLE cycle.
- Timing:
  - out_valid asserts 2*TAPS+1 clocks after the accepting edge;
  - with in_valid held high, throughput is one sample per 2*TAPS+2 clocks;
  - out_valid coincides with in_ready, so back-to-back samples are accepted on the out_valid cycle.
- Arithmetic rules:
  - >>> is arithmetic shift with truncation toward -inf;
  - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. 0x8000..0x7FFF at WIDTH=16;
  - no wrap-around on any output.
- weights_clr:
  - in IDLE it zeroes all weights at the next edge; the delay line is kept; it takes priority over in_valid (no accept that cycle);
  - while busy it is ignored and not queued.
- dout, error and weights are held stable between out_valid pulses. weights changes only during UPDATE, on weights_clr, or on reset.
- Inputs other than in_valid and weights_clr are don't-care outside the accept cycle.

Optional Feature:
- ADAPTIVE_FILTER_LEAK_EN defined: leaky LMS. During UPDATE with adapt_en set, w[k] <= sat(w[k] - (w[k] >>> LEAK_SHIFT) + ((mu_e*x[k]) >>> FRAC)). With adapt_en clear, weights are unchanged (no leak).
- Undefined: standard LMS as above; LEAK_SHIFT unused.
- Latency and throughput are identical either way.

Test Plan (WIDTH=16, FRAC=7, TAPS=2, macro undefined unless stated):
1. Hold rstn=0 for 1 clk, then release -> dout=0, error=0, weights={0,0}, out_valid=0, in_ready=1.
2. adapt_en=0, din=128, desired=256, step=64 -> out_valid exactly 5 clks after accept; dout=0; error=256; weights stay {0,0}.
3. Update and convergence: adapt_en=1, step=64, din=128, desired=256 -> error=256, mu_e=128, w[0]=128, w[1]=0. Second sample din=128, desired=256 -> dout=128, error=128, w[0]=192, w[1]=64.
4. Saturation: step=0x7FFF, din=0x7FFF, desired=0x7FFF, repeated 4 times -> w[0] reaches 0x7FFF and stays there; dout never goes negative; error never wraps.
5. Handshake:
   - in_valid held high for 3 samples -> accepts spaced exactly 6 clks apart; in_ready low for the 5 busy clks;
   - assert weights_clr with in_valid in IDLE -> no accept, weights={0,0} next clk;
   - assert weights_clr during FILTER -> ignored.
6. Reset mid-UPDATE (rstn=0 on 1st UPDATE cycle) -> all outputs and weights 0 next clk, out_valid never pulses. Repeat scenario 3 with ADAPTIVE_FILTER_LEAK_EN and LEAK_SHIFT=1 -> second-sample w[0]=128.
